// File: rtl/count_seq_ctrl_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | count_seq_pkg : state encoding and hex-to-7-segment decode           |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
package count_seq_pkg;

  localparam logic [1:0] C_ST_IDLE  = 2'b00;
  localparam logic [1:0] C_ST_RUN   = 2'b01;
  localparam logic [1:0] C_ST_PAUSE = 2'b10;
  localparam logic [1:0] C_ST_DONE  = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE  = C_ST_IDLE,
    ST_RUN   = C_ST_RUN,
    ST_PAUSE = C_ST_PAUSE,
    ST_DONE  = C_ST_DONE
  } state_t;

  // Active-low segment pattern, bit order {g,f,e,d,c,b,a}
  function automatic logic [6:0] hex_to_seg(input logic [3:0] hex);
    logic [6:0] seg;
    case (hex)
      4'h0: seg = 7'h40;
      4'h1: seg = 7'h79;
      4'h2: seg = 7'h24;
      4'h3: seg = 7'h30;
      4'h4: seg = 7'h19;
      4'h5: seg = 7'h12;
      4'h6: seg = 7'h02;
      4'h7: seg = 7'h78;
      4'h8: seg = 7'h00;
      4'h9: seg = 7'h10;
      4'hA: seg = 7'h08;
      4'hB: seg = 7'h03;
      4'hC: seg = 7'h46;
      4'hD: seg = 7'h21;
      4'hE: seg = 7'h06;
      default: seg = 7'h0E;
    endcase
    return seg;
  endfunction

endpackage
`default_nettype wire

// File: rtl/count_seq_ctrl_tick_gen.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tick_gen : count-enable divider, fires when count equals div_val     |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module tick_gen #(
  parameter int DIV_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic             clr,
  input  logic [DIV_W-1:0] div_val,
  output logic             tick
);

  logic [DIV_W-1:0] r_div_cnt;

  assign tick = en && (r_div_cnt == div_val);

  // Holds its value while disabled so a paused run resumes mid-period
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_div_cnt <= '0;
    end else if (clr) begin
      r_div_cnt <= '0;
    end else if (en) begin
      r_div_cnt <= tick ? '0 : r_div_cnt + DIV_W'(1);
    end
  end

endmodule
`default_nettype wire

// File: rtl/count_seq_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | count_seq_ctrl : run/pause/step/clear sequencer for a hex counter    |
// | with registered 7-segment output. Rev 1.0                            |
// +----------------------------------------------------------------------+
module count_seq_ctrl
  import count_seq_pkg::*;
#(
  parameter int DIV_W          = 16,
  parameter bit SEG_ACTIVE_LOW = 1'b1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start_i,
  input  logic             stop_i,
  input  logic             step_i,
  input  logic             clear_i,
  input  logic             dir_i,
  input  logic             wrap_i,
  input  logic [DIV_W-1:0] div_val_i,
  output logic [3:0]       count_o,
  output logic [6:0]       seg_o,
  output logic             tick_o,
  output logic [1:0]       state_o,
  output logic             done_o
);

  localparam logic [6:0] C_SEG_RST = SEG_ACTIVE_LOW ? hex_to_seg(4'h0) : ~hex_to_seg(4'h0);

  state_t           r_state;
  logic [3:0]       r_count;
  logic [6:0]       r_seg;
  logic             r_tick;
  logic             r_done;
  logic [DIV_W-1:0] r_div_lat;

  state_t           w_next_state;
  logic [3:0]       w_next_count;
  logic             w_adv_req;
  logic             w_adv_ok;
  logic             w_blocked;
  logic             w_tg_en;
  logic             w_tg_clr;
  logic             w_tg_tick;
  logic             w_lat_load;
  logic [6:0]       w_seg_raw;
  logic [6:0]       w_seg_next;

  assign w_tg_en = (r_state == ST_RUN) && !stop_i;

  tick_gen #(
    .DIV_W (DIV_W)
  ) u_tick_gen (
    .clk     (clk),
    .rst_n   (rst_n),
    .en      (w_tg_en),
    .clr     (w_tg_clr),
    .div_val (r_div_lat),
    .tick    (w_tg_tick)
  );

  assign w_blocked = !wrap_i && (dir_i ? (r_count == 4'hF) : (r_count == 4'h0));

  // Only the highest-priority asserted command is acted on: clear > stop > start > step
  always_comb begin
    w_next_state = r_state;
    w_next_count = r_count;
    w_adv_req    = 1'b0;
    w_adv_ok     = 1'b0;
    w_tg_clr     = 1'b0;
    w_lat_load   = 1'b0;
    if (clear_i) begin
      w_next_state = ST_IDLE;
      w_next_count = 4'h0;
      w_tg_clr     = 1'b1;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (!stop_i) begin
            if (start_i) begin
              w_next_state = ST_RUN;
              w_tg_clr     = 1'b1;
              w_lat_load   = 1'b1;
            end else if (step_i) begin
              w_adv_req = 1'b1;
            end
          end
        end
        ST_RUN: begin
          if (stop_i) begin
            w_next_state = ST_PAUSE;
          end else if (w_tg_tick) begin
            w_adv_req = 1'b1;
          end
        end
        ST_PAUSE: begin
          if (!stop_i) begin
            if (start_i) begin
              w_next_state = ST_RUN;
            end else if (step_i) begin
              w_adv_req = 1'b1;
            end
          end
        end
        default: begin
          w_next_state = r_state;
        end
      endcase
      // A saturated advance leaves the count alone and parks in DONE
      if (w_adv_req) begin
        if (w_blocked) begin
          w_next_state = ST_DONE;
        end else begin
          w_adv_ok     = 1'b1;
          w_next_count = dir_i ? r_count + 4'd1 : r_count - 4'd1;
        end
      end
    end
  end

  assign w_seg_raw  = hex_to_seg(w_next_count);
  assign w_seg_next = SEG_ACTIVE_LOW ? w_seg_raw : ~w_seg_raw;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_count   <= 4'h0;
      r_seg     <= C_SEG_RST;
      r_tick    <= 1'b0;
      r_done    <= 1'b0;
      r_div_lat <= '0;
    end else begin
      r_count <= w_next_count;
      r_seg   <= w_seg_next;
      r_tick  <= w_adv_ok;
      r_done  <= (w_next_state == ST_DONE);
      if (w_lat_load) begin
        r_div_lat <= div_val_i;
      end
    end
  end

  assign count_o = r_count;
  assign seg_o   = r_seg;
  assign tick_o  = r_tick;
  assign state_o = r_state;
  assign done_o  = r_done;

endmodule
`default_nettype wire

// File: tb/tb_count_seq_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_count_seq_ctrl : vector table, directed sequences, random run     |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module tb_count_seq_ctrl;

  localparam int DIV_W = 16;
  localparam int M_IDLE = 0, M_RUN = 1, M_PAUSE = 2, M_DONE = 3;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             start_i = 1'b0, stop_i = 1'b0, step_i = 1'b0, clear_i = 1'b0;
  logic             dir_i = 1'b1, wrap_i = 1'b1;
  logic [DIV_W-1:0] div_val_i = '0;
  logic [3:0]       count_o;
  logic [6:0]       seg_o;
  logic             tick_o;
  logic [1:0]       state_o;
  logic             done_o;

  always #5 clk = ~clk;

  count_seq_ctrl #(.DIV_W(DIV_W), .SEG_ACTIVE_LOW(1'b1)) dut (
    .clk(clk), .rst_n(rst_n), .start_i(start_i), .stop_i(stop_i), .step_i(step_i),
    .clear_i(clear_i), .dir_i(dir_i), .wrap_i(wrap_i), .div_val_i(div_val_i),
    .count_o(count_o), .seg_o(seg_o), .tick_o(tick_o), .state_o(state_o), .done_o(done_o)
  );

  int n_tests = 0;
  int n_fail  = 0;

  logic [6:0] seg_tab [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                               7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};

  // Reference model: mode, count value, cycles elapsed in the current tick period
  int m_state = M_IDLE, m_count = 0, m_elapsed = 0, m_lat = 0;
  logic m_tick = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic m_advance(input logic d, input logic w);
    int n;
    n = m_count + (d ? 1 : -1);
    if (n >= 0 && n <= 15) begin
      m_count = n; m_tick = 1'b1;
    end else if (w) begin
      m_count = (n + 16) % 16; m_tick = 1'b1;
    end else begin
      m_state = M_DONE;
    end
  endtask

  task automatic m_step(input logic st, sp, se, cl, d, w, input int dv);
    m_tick = 1'b0;
    if (cl) begin
      m_state = M_IDLE; m_count = 0; m_elapsed = 0;
    end else if (m_state == M_RUN) begin
      if (sp) m_state = M_PAUSE;
      else if (m_elapsed == m_lat) begin m_elapsed = 0; m_advance(d, w); end
      else m_elapsed++;
    end else if ((m_state == M_IDLE || m_state == M_PAUSE) && !sp) begin
      if (st) begin
        if (m_state == M_IDLE) begin m_elapsed = 0; m_lat = dv; end
        m_state = M_RUN;
      end else if (se) begin
        m_advance(d, w);
      end
    end
  endtask

  task automatic m_reset();
    m_state = M_IDLE; m_count = 0; m_elapsed = 0; m_lat = 0; m_tick = 1'b0;
  endtask

  task automatic cmp_model(input string tag);
    chk({tag, " count"}, 32'(count_o), 32'(m_count));
    chk({tag, " seg"},   32'(seg_o),   32'(seg_tab[m_count]));
    chk({tag, " tick"},  32'(tick_o),  32'(m_tick));
    chk({tag, " state"}, 32'(state_o), 32'(m_state));
    chk({tag, " done"},  32'(done_o),  32'(m_state == M_DONE));
  endtask

  task automatic drive(input logic st, sp, se, cl, d, w, input int dv);
    start_i = st; stop_i = sp; step_i = se; clear_i = cl;
    dir_i = d; wrap_i = w; div_val_i = DIV_W'(dv);
  endtask

  task automatic cycle(input string tag, input logic st, sp, se, cl, d, w, input int dv);
    drive(st, sp, se, cl, d, w, dv);
    @(posedge clk);
    m_step(st, sp, se, cl, d, w, dv);
    #1;
    cmp_model(tag);
  endtask

  typedef struct {
    logic st, sp, se, cl, d, w;
    int   dv;
    int   e_cnt;
    int   e_st;
    logic e_tick;
  } vec_t;

  function automatic vec_t mk(input logic st, sp, se, cl, d, w, input int dv, ec, es, input logic et);
    vec_t v;
    v.st = st; v.sp = sp; v.se = se; v.cl = cl; v.d = d; v.w = w;
    v.dv = dv; v.e_cnt = ec; v.e_st = es; v.e_tick = et;
    return v;
  endfunction

  vec_t vt [18];

  initial begin
    int last_tick, n_ticks, k;
    logic found;

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    chk("rst count", 32'(count_o), 0);
    chk("rst seg",   32'(seg_o),   32'h40);
    chk("rst tick",  32'(tick_o),  0);
    chk("rst state", 32'(state_o), 0);
    chk("rst done",  32'(done_o),  0);
    rst_n = 1'b1;
    for (int i = 0; i < 10; i++) cycle("idle", 0, 0, 0, 0, 1, 1, 0);

    // Vector table: st sp se cl d w dv | count state tick
    vt[0]  = mk(0,0,1,0,1,1,0,  1,0,1);
    vt[1]  = mk(0,0,1,0,1,1,0,  2,0,1);
    vt[2]  = mk(0,0,0,0,1,1,0,  2,0,0);
    vt[3]  = mk(0,0,1,0,0,1,0,  1,0,1);
    vt[4]  = mk(1,0,0,0,1,1,1,  1,1,0);
    vt[5]  = mk(0,0,0,0,1,1,1,  1,1,0);
    vt[6]  = mk(0,0,0,0,1,1,7,  2,1,1);
    vt[7]  = mk(0,0,1,0,1,1,1,  2,1,0);
    vt[8]  = mk(0,1,0,0,1,1,1,  2,2,0);
    vt[9]  = mk(0,0,1,0,1,1,1,  3,2,1);
    vt[10] = mk(1,0,0,0,1,1,1,  3,1,0);
    vt[11] = mk(0,0,0,0,1,1,1,  4,1,1);
    vt[12] = mk(0,0,0,1,1,1,1,  0,0,0);
    vt[13] = mk(0,0,1,0,0,1,1, 15,0,1);
    vt[14] = mk(0,0,1,0,1,0,1, 15,3,0);
    vt[15] = mk(1,0,0,0,1,1,1, 15,3,0);
    vt[16] = mk(0,0,1,0,1,1,1, 15,3,0);
    vt[17] = mk(0,0,0,1,1,1,1,  0,0,0);
    for (int i = 0; i < 18; i++) begin
      drive(vt[i].st, vt[i].sp, vt[i].se, vt[i].cl, vt[i].d, vt[i].w, vt[i].dv);
      @(posedge clk);
      m_step(vt[i].st, vt[i].sp, vt[i].se, vt[i].cl, vt[i].d, vt[i].w, vt[i].dv);
      #1;
      chk($sformatf("vec%0d count", i), 32'(count_o), 32'(vt[i].e_cnt));
      chk($sformatf("vec%0d state", i), 32'(state_o), 32'(vt[i].e_st));
      chk($sformatf("vec%0d tick", i),  32'(tick_o),  32'(vt[i].e_tick));
      chk($sformatf("vec%0d seg", i),   32'(seg_o),   32'(seg_tab[vt[i].e_cnt]));
      chk($sformatf("vec%0d done", i),  32'(done_o),  32'(vt[i].e_st == M_DONE));
    end

    // Period 5 run through a full wrap
    cycle("p5 start", 1, 0, 0, 0, 1, 1, 4);
    last_tick = 0; n_ticks = 0;
    for (int c = 1; c <= 80; c++) begin
      cycle("p5 run", 0, 0, 0, 0, 1, 1, 4);
      if (tick_o) begin
        chk("p5 interval", 32'(c - last_tick), 5);
        last_tick = c; n_ticks++;
        if (count_o == 4'hA) chk("p5 seg A", 32'(seg_o), 32'h08);
      end
    end
    chk("p5 ticks", 32'(n_ticks), 16);
    chk("p5 wrapped", 32'(count_o), 0);

    // Stop coincident with a due tick at count 3
    cycle("s3 clear", 0, 0, 0, 1, 1, 1, 4);
    cycle("s3 start", 1, 0, 0, 0, 1, 1, 4);
    found = 1'b0; k = 0;
    while (!found && k < 40) begin
      cycle("s3 run", 0, 0, 0, 0, 1, 1, 4);
      found = tick_o && (count_o == 4'h3);
      k++;
    end
    chk("s3 reached", 32'(found), 1);
    for (int i = 0; i < 4; i++) cycle("s3 run", 0, 0, 0, 0, 1, 1, 4);
    cycle("s3 stop", 0, 1, 0, 0, 1, 1, 4);
    chk("s3 stop count", 32'(count_o), 3);
    chk("s3 stop state", 32'(state_o), 2);
    cycle("s3 resume", 1, 0, 0, 0, 1, 1, 4);
    cycle("s3 tick", 0, 0, 0, 0, 1, 1, 4);
    chk("s3 resume count", 32'(count_o), 4);
    chk("s3 resume tick", 32'(tick_o), 1);

    // Saturate at 0 from a step, then DONE exit via clear only
    cycle("sat clear", 0, 0, 0, 1, 0, 0, 0);
    cycle("sat step", 0, 0, 1, 0, 0, 0, 0);
    chk("sat done", 32'(done_o), 1);
    chk("sat state", 32'(state_o), 3);
    cycle("sat start", 1, 0, 0, 0, 0, 0, 0);
    chk("sat start ignored", 32'(state_o), 3);
    cycle("sat exit", 0, 0, 0, 1, 0, 0, 0);
    chk("sat exit done", 32'(done_o), 0);

    // Every-cycle advance, then clear beats start
    cycle("d0 start", 1, 0, 0, 0, 1, 1, 0);
    for (int i = 0; i < 5; i++) cycle("d0 run", 0, 0, 0, 0, 1, 1, 0);
    chk("d0 count", 32'(count_o), 5);
    cycle("d0 clr+start", 1, 0, 0, 1, 1, 1, 0);
    chk("d0 clr state", 32'(state_o), 0);

    // Asynchronous reset mid-run at count 7
    cycle("ar start", 1, 0, 0, 0, 1, 1, 0);
    for (int i = 0; i < 7; i++) cycle("ar run", 0, 0, 0, 0, 1, 1, 0);
    chk("ar pre count", 32'(count_o), 7);
    #3 rst_n = 1'b0;
    #1;
    m_reset();
    cmp_model("ar async");
    #2 rst_n = 1'b1;
    drive(0, 0, 0, 0, 1, 1, 0);

    // Random commands against the model
    for (int i = 0; i < 500; i++) begin
      int r;
      logic st, sp, se, cl;
      r = int'($urandom_range(0, 99));
      cl = (r < 3);
      st = (r >= 3 && r < 15);
      sp = (r >= 15 && r < 25);
      se = (r >= 25 && r < 40);
      cycle("rand", st, sp, se, cl, 1'($urandom_range(0, 1)),
            ($urandom_range(0, 3) != 0), int'($urandom_range(0, 5)));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
